i2s_tx_clkgen_master: RTL
=========================

Name: i2s_tx_clkgen_master

Overview:
- I2S master transmitter with internal clock generation.
- Derives BCK and LRCK from MCLK, accepts stereo PCM samples over a valid/ready handshake into a one-entry holding buffer, and serializes them as standard I2S: MSB first, one-BCK delay after the LRCK edge.
- Sits between the PCM processing chain and an external DAC, or feeds the existing I2S-to-PCM receiver when no upstream clock source is present.

Parameters:
- PCM_BIT_WIDTH, 32, sample width per channel; must be <= SLOT_WIDTH.
- SLOT_WIDTH, 32, BCK periods per channel slot; frame = 2*SLOT_WIDTH BCK.
- BCK_DIV_HALF, 1, MCLK cycles per BCK half-period; BCK = MCLK/(2*BCK_DIV_HALF); must be >= 1.

Ports:
- MCLK_I  in  1  master clock; the only clock.
- RST_I  in  1  asynchronous reset, active-high.
- VALID_I  in  1  DATAL_I/DATAR_I hold a valid sample pair.
- DATAL_I  in  PCM_BIT_WIDTH  left sample, signed two's complement.
- DATAR_I  in  PCM_BIT_WIDTH  right sample, signed two's complement.
- READY_O  out  1  holding buffer empty; transfer occurs when VALID_I && READY_O at a rising MCLK_I edge.
- MCLK_O  out  1  MCLK_I passed through combinationally.
- BCK_O  out  1  bit clock, registered.
- LRCK_O  out  1  word clock; low = left, high = right; registered.
- DATA_O  out  1  serial data; changes only on BCK_O falling edges; registered.
- UNDERRUN_O  out  1  one-MCLK pulse when a frame starts with an empty buffer.

Behaviour:
- Reset (asynchronous, active-high) forces: BCK_O=0, LRCK_O=0, DATA_O=0, UNDERRUN_O=0, READY_O=1.
- Reset also clears: holding buffer full flag, divider counter, both shift registers; frame position p = 2*SLOT_WIDTH-1.
- All state updates on the rising edge of MCLK_I.
- Divider:
  - Counts 0..BCK_DIV_HALF-1.
  - On wrap, BCK_O toggles.
  - A 1->0 toggle is a "fall event". All of p, LRCK_O, DATA_O and UNDERRUN_O update on the same MCLK edge as the BCK_O fall.
- Frame position:
  - On each fall event, p advances modulo 2*SLOT_WIDTH.
  - Entering p=0 is a "frame load".
- LRCK_O = 1 for p in SLOT_WIDTH-1 .. 2*SLOT_WIDTH-2; 0 otherwise. LRCK therefore leads each channel's MSB by one BCK.
- DATA_O:
  - Left bit k (k=0 is MSB) at p=k for k < PCM_BIT_WIDTH.
  - Right bit k at p=SLOT_WIDTH+k.
  - Slot positions at or beyond PCM_BIT_WIDTH within a slot output 0.
- Frame load with buffer full:
  - Shift registers load the held L/R pair; DATA_O = left MSB.
  - Full flag clears and READY_O rises.
- Frame load with buffer empty:
  - Shift registers load zero; DATA_O=0.
  - UNDERRUN_O = 1 for exactly one MCLK cycle.
- Accept: VALID_I && READY_O captures DATAL_I/DATAR_I, sets full and drops READY_O on the next edge.
- Simultaneous accept and frame load: READY_O=1 implies buffer empty. The frame loads zero and flags underrun; the accepted pair is held for the following frame.
- At most one pair is accepted per frame period after the first. VALID_I with READY_O=0 is ignored (back-pressure); the upstream must hold data.
- Latency: a pair accepted before a frame load appears MSB-first starting at that load.
  - First fall event after reset occurs 2*BCK_DIV_HALF MCLK cycles after reset release, and is a frame load.
- Reset asserted mid-frame: outputs go to their reset values immediately; the held sample is discarded; the next frame restarts at p=0.

Test Plan:
- Reset then idle, default params, VALID_I=0:
  - BCK_O period = 2 MCLK cycles; LRCK_O period = 128 MCLK cycles.
  - LRCK_O rises at fall event p=31 and falls at p=63.
  - DATA_O all zero; UNDERRUN_O pulses once per 128 MCLK cycles.
- Single transfer DATAL_I=32'h80000001, DATAR_I=32'h7FFFFFFE, offered before the first frame load:
  - Left slot DATA_O = 1, then thirty 0s, then 1.
  - Right slot DATA_O = 0, thirty 1s, then 0.
  - Sampled on BCK_O rising edges; no UNDERRUN_O in that frame.
- Back-pressure, VALID_I held high with incrementing data:
  - READY_O drops the edge after the accept.
  - READY_O rises on the frame-load edge; exactly one pair is consumed per 128 MCLK cycles; no sample is skipped or duplicated.
- PCM_BIT_WIDTH=24, SLOT_WIDTH=32, DATAL_I=24'hA5A5A5:
  - Positions 0..23 carry A5A5A5 MSB-first; positions 24..31 are 0.
  - LRCK_O edge timing is unchanged.
- BCK_DIV_HALF=2: BCK_O period = 4 MCLK cycles; DATA_O and LRCK_O change only on the same MCLK edge as a BCK_O fall.
- Assert RST_I mid-right-slot with the buffer full:
  - All outputs reset immediately; READY_O=1; the held sample is lost.
  - After release, the first frame load occurs 2*BCK_DIV_HALF MCLK cycles later with DATA_O=0 and an UNDERRUN_O pulse.

Source files
------------

// File: rtl/i2s_tx_clkgen_master.sv
// I2S master transmitter: derives BCK/LRCK from MCLK and serializes a stereo
// PCM pair from a one-entry holding buffer, MSB first, one BCK after LRCK.
module i2s_tx_clkgen_master #(
  parameter int PCM_BIT_WIDTH = 32,
  parameter int SLOT_WIDTH    = 32,
  parameter int BCK_DIV_HALF  = 1
) (
  input  logic                            MCLK_I,
  input  logic                            RST_I,
  input  logic                            VALID_I,
  input  logic signed [PCM_BIT_WIDTH-1:0] DATAL_I,
  input  logic signed [PCM_BIT_WIDTH-1:0] DATAR_I,
  output logic                            READY_O,
  output logic                            MCLK_O,
  output logic                            BCK_O,
  output logic                            LRCK_O,
  output logic                            DATA_O,
  output logic                            UNDERRUN_O
);

  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int P_W   = $clog2(FRAME);
  localparam int DIV_W = (BCK_DIV_HALF > 1) ? $clog2(BCK_DIV_HALF) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV_HALF - 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME - 1);
  localparam logic [P_W-1:0]   P_LRCK   = P_W'(SLOT_WIDTH - 1);
  localparam logic [P_W-1:0]   P_RIGHT  = P_W'(SLOT_WIDTH);

  logic [DIV_W-1:0]                r_div;
  logic                            r_bck;
  logic [P_W-1:0]                  r_p;
  logic                            r_lrck;
  logic                            r_data;
  logic                            r_underrun;
  logic                            r_full;
  logic signed [PCM_BIT_WIDTH-1:0] r_hold_l;
  logic signed [PCM_BIT_WIDTH-1:0] r_hold_r;
  logic [PCM_BIT_WIDTH-1:0]        r_sh_l;
  logic [PCM_BIT_WIDTH-1:0]        r_sh_r;

  logic           w_wrap;
  logic           w_fall;
  logic [P_W-1:0] w_p_nxt;
  logic           w_load;
  logic           w_accept;
  logic           w_lrck_nxt;
  logic           w_left;

  assign w_wrap     = (r_div == DIV_LAST);
  assign w_fall     = w_wrap & r_bck;
  assign w_p_nxt    = (r_p == P_LAST) ? '0 : r_p + 1'b1;
  assign w_load     = w_fall && (w_p_nxt == '0);
  assign w_accept   = VALID_I & ~r_full;
  // LRCK flips one position before each slot so it leads the MSB by one BCK.
  assign w_lrck_nxt = (w_p_nxt >= P_LRCK) && (w_p_nxt != P_LAST);
  assign w_left     = (w_p_nxt < P_RIGHT);

  assign READY_O    = ~r_full;
  assign MCLK_O     = MCLK_I;
  assign BCK_O      = r_bck;
  assign LRCK_O     = r_lrck;
  assign DATA_O     = r_data;
  assign UNDERRUN_O = r_underrun;

  always_ff @(posedge MCLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_div      <= '0;
      r_bck      <= 1'b0;
      r_p        <= P_LAST;
      r_lrck     <= 1'b0;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
      r_full     <= 1'b0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
    end else begin
      r_div      <= w_wrap ? '0 : r_div + 1'b1;
      r_underrun <= 1'b0;
      if (w_wrap) r_bck <= ~r_bck;
      if (w_fall) begin
        r_p    <= w_p_nxt;
        r_lrck <= w_lrck_nxt;
        if (w_load) begin
          r_underrun <= ~r_full;
          if (r_full) begin
            r_data <= r_hold_l[PCM_BIT_WIDTH-1];
            r_sh_l <= $unsigned(r_hold_l) << 1;
            r_sh_r <= $unsigned(r_hold_r);
          end else begin
            r_data <= 1'b0;
            r_sh_l <= '0;
            r_sh_r <= '0;
          end
        end else if (w_left) begin
          // Zeros shift in behind the sample, padding the slot past PCM_BIT_WIDTH.
          r_data <= r_sh_l[PCM_BIT_WIDTH-1];
          r_sh_l <= r_sh_l << 1;
        end else begin
          r_data <= r_sh_r[PCM_BIT_WIDTH-1];
          r_sh_r <= r_sh_r << 1;
        end
      end
      // A frame load only ever consumes a full buffer, so it never races an accept.
      if (w_load && r_full) r_full <= 1'b0;
      else if (w_accept)    r_full <= 1'b1;
    end
  end

  always_ff @(posedge MCLK_I) begin
    if (w_accept) begin
      r_hold_l <= DATAL_I;
      r_hold_r <= DATAR_I;
    end
  end

endmodule
